// File: rtl/disp_sched_pkg.sv
// Shared types and helpers for the display message scheduler.
//   state_t     : scheduler FSM states
//   FRAME_BLANK : all segments off (segments are active-low)
//   DIGIT_W     : bits per seven-segment digit in a 64-bit frame
//   rotl_digit  : rotate a frame left by one digit (digit 2 becomes digit 1)
package disp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [63:0] FRAME_BLANK = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int          DIGIT_W     = 8;

  function automatic logic [63:0] rotl_digit(input logic [63:0] f);
    return {f[63-DIGIT_W:0], f[63:64-DIGIT_W]};
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick prescaler.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous restart of the count at 0
//   tick       : high for the one cycle where the count sits at TICK_DIV-1
module sec_tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (clr || (r_cnt == LAST)) r_cnt <= '0;
    else                             r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/disp_msg_scheduler.sv
// Arbitrates the 8-digit display between notice requesters and the base frame.
// The lowest-index requester wins from IDLE, its frame is snapshotted and held
// for HOLD_SEC ticks (optionally scrolling one digit per tick), then a one-cycle
// done pulse is given. Also pulses timeout after TIMEOUT_SEC quiet idle ticks.
//   req/frame_req/scroll_req : per-requester level request, frame, scroll enable
//   frame_base               : frame shown while nobody holds the display
//   activity                 : key/coin event, restarts the inactivity count
//   grant/busy/done          : one-hot owner, hold active, end-of-hold pulse
//   frame_out                : registered active-low frame to the scan driver
//   timeout/tick             : inactivity pulse, 1 s pulse
module disp_msg_scheduler
  import disp_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TICK_DIV    = 100000000,
  parameter int HOLD_SEC    = 2,
  parameter int TIMEOUT_SEC = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [64*N_REQ-1:0]  frame_req,
  input  logic [N_REQ-1:0]     scroll_req,
  input  logic [63:0]          frame_base,
  input  logic                 activity,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic [N_REQ-1:0]     done,
  output logic [63:0]          frame_out,
  output logic                 timeout,
  output logic                 tick
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HC_W  = $clog2(HOLD_SEC + 1);
  localparam int IC_W  = $clog2(TIMEOUT_SEC + 1);
  // Hold ends on the tick that would take the count from HOLD_SEC-1 to HOLD_SEC.
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_SEC - 1);
  localparam logic [IC_W-1:0] IDLE_TERM = IC_W'(TIMEOUT_SEC);

  state_t            r_state, w_next;
  logic [IDX_W-1:0]  r_owner;
  logic [HC_W-1:0]   r_hold_cnt;
  logic [IC_W-1:0]   r_idle_cnt;
  logic              r_scroll;
  logic [63:0]       r_frame;

  logic [IDX_W-1:0]  w_win_idx;
  logic [63:0]       w_win_frame;
  logic              w_win_scroll;
  logic              w_any_req;
  logic              w_owner_req;
  logic              w_start;
  logic              w_tick;
  logic [N_REQ-1:0]  w_owner_oh;

  // Fixed-priority pick: scanning downward lets the lowest set index win.
  always_comb begin
    w_win_idx    = '0;
    w_win_frame  = frame_req[63:0];
    w_win_scroll = scroll_req[0];
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_win_idx    = IDX_W'(i);
        w_win_frame  = frame_req[64*i +: 64];
        w_win_scroll = scroll_req[i];
      end
    end
  end

  assign w_any_req   = |req;
  assign w_owner_req = req[r_owner];
  assign w_owner_oh  = N_REQ'(1) << r_owner;
  assign w_start     = (r_state == ST_IDLE) && w_any_req;

  // Prescaler restarts on grant so every hold lasts exactly HOLD_SEC*TICK_DIV cycles.
  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start),
    .tick  (w_tick)
  );

  assign tick = w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    grant  = '0;
    busy   = 1'b0;
    done   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        grant = w_owner_oh;
        busy  = 1'b1;
        // Withdrawal beats a coinciding terminal tick: no done for an abandoned hold.
        if (!w_owner_req)                           w_next = ST_IDLE;
        else if (w_tick && (r_hold_cnt == HOLD_LAST)) w_next = ST_DONE;
      end
      ST_DONE: begin
        grant  = w_owner_oh;
        done   = w_owner_oh;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= '0;
      r_hold_cnt <= '0;
      r_scroll   <= 1'b0;
      r_frame    <= FRAME_BLANK;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner    <= w_win_idx;
            r_hold_cnt <= '0;
            r_scroll   <= w_win_scroll;
            r_frame    <= w_win_frame;
          end else begin
            r_frame    <= frame_base;
          end
        end
        ST_HOLD: begin
          if (w_owner_req && w_tick) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
            if (r_scroll) r_frame <= rotl_digit(r_frame);
          end
        end
        default: ;
      endcase
    end
  end

  assign frame_out = r_frame;

  // Inactivity counter: the terminal value is shown for one cycle as the
  // timeout pulse, then wraps. Activity on the terminal tick clears it first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if ((r_idle_cnt == IDLE_TERM) || (r_state != ST_IDLE) || w_any_req || activity) begin
      r_idle_cnt <= '0;
    end else if (w_tick) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign timeout = (r_idle_cnt == IDLE_TERM);

endmodule

// File: tb/tb_disp_msg_scheduler.sv
module tb_disp_msg_scheduler;

  localparam int N_REQ       = 4;
  localparam int TICK_DIV    = 4;
  localparam int HOLD_SEC    = 2;
  localparam int TIMEOUT_SEC = 3;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic [3:0]   req        = '0;
  logic [255:0] frame_req  = '0;
  logic [3:0]   scroll_req = '0;
  logic [63:0]  frame_base = '0;
  logic         activity   = 1'b0;
  logic [3:0]   grant;
  logic         busy;
  logic [3:0]   done;
  logic [63:0]  frame_out;
  logic         timeout;
  logic         tick;

  disp_msg_scheduler #(
    .N_REQ(N_REQ), .TICK_DIV(TICK_DIV), .HOLD_SEC(HOLD_SEC), .TIMEOUT_SEC(TIMEOUT_SEC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .frame_req(frame_req), .scroll_req(scroll_req),
    .frame_base(frame_base), .activity(activity), .grant(grant), .busy(busy), .done(done),
    .frame_out(frame_out), .timeout(timeout), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: owner index (-1 = nobody), seconds elapsed in the hold,
  // done-cycle flag, cycles into the current second, quiet idle seconds.
  int          m_owner;
  int          m_secs;
  bit          m_done;
  bit          m_scroll;
  int          m_pre;
  int          m_idle;
  logic [63:0] m_frame;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_secs   = 0;
    m_done   = 1'b0;
    m_scroll = 1'b0;
    m_pre    = 0;
    m_idle   = 0;
    m_frame  = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  task automatic model_step();
    bit t;
    bit start;
    int w;
    t     = (m_pre == TICK_DIV - 1);
    start = (m_owner < 0) && (req != 0);
    if (m_idle == TIMEOUT_SEC || m_owner >= 0 || req != 0 || activity) m_idle = 0;
    else if (t) m_idle = m_idle + 1;
    if (start) m_pre = 0;
    else       m_pre = t ? 0 : m_pre + 1;
    if (m_owner < 0) begin
      if (start) begin
        w = 0;
        while (!req[w]) w++;
        m_owner  = w;
        m_secs   = 0;
        m_scroll = scroll_req[w];
        m_frame  = frame_req[64*w +: 64];
      end else begin
        m_frame = frame_base;
      end
    end else if (m_done) begin
      m_owner = -1;
      m_done  = 1'b0;
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else if (t) begin
      m_secs = m_secs + 1;
      if (m_scroll) m_frame = (m_frame << 8) | (m_frame >> 56);
      if (m_secs == HOLD_SEC) m_done = 1'b1;
    end
  endtask

  // Compare all outputs against the model mid-cycle, then advance one edge.
  task automatic cyc();
    logic [3:0] eg;
    @(negedge clk);
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    chk("grant",     64'(grant),     64'(eg));
    chk("busy",      64'(busy),      64'(m_owner >= 0 && !m_done));
    chk("done",      64'(done),      64'(m_done ? eg : 4'b0));
    chk("tick",      64'(tick),      64'(m_pre == TICK_DIV - 1));
    chk("timeout",   64'(timeout),   64'(m_idle == TIMEOUT_SEC));
    chk("frame_out", frame_out,      m_frame);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_grant",   64'(grant),   64'(4'b0));
    chk("rst_busy",    64'(busy),    64'(1'b0));
    chk("rst_done",    64'(done),    64'(4'b0));
    chk("rst_timeout", 64'(timeout), 64'(1'b0));
    chk("rst_tick",    64'(tick),    64'(1'b0));
    chk("rst_frame",   frame_out,    64'hFFFF_FFFF_FFFF_FFFF);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_frames();
    for (int k = 0; k < 8; k++) frame_req[32*k +: 32] = $urandom;
  endtask

  logic [63:0] fr_snap;
  bit          quiet;

  initial begin
    model_reset();
    frame_base = {$urandom, $urandom};
    rand_frames();
    @(posedge clk);
    #1;
    do_reset();

    // Reset in the middle of a hold, then back to the base frame.
    req = 4'b0001;
    cyc(); cyc(); cyc();
    chk("t1_busy_pre", 64'(busy), 64'(1'b1));
    req = 4'b0000;
    do_reset();
    cyc(); cyc();
    chk("t1_grant", 64'(grant), 64'(4'b0));
    chk("t1_base",  frame_out,  frame_base);

    // Lowest index wins, frame snapshotted for the whole hold.
    req = 4'b0110;
    cyc();
    chk("t2_grant", 64'(grant), 64'(4'b0010));
    fr_snap = frame_req[127:64];
    chk("t2_frame", frame_out, fr_snap);
    rand_frames();
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("t2_hold", frame_out, fr_snap);
    end
    cyc();
    chk("t2_done", 64'(done), 64'(4'b0010));
    req = 4'b0100;
    cyc();
    chk("t2_idle", 64'(grant), 64'(4'b0));
    cyc();
    chk("t2_grant2", 64'(grant), 64'(4'b0100));
    chk("t2_frame2", frame_out, frame_req[191:128]);
    req = 4'b0000;
    cyc(); cyc();

    // Scrolling frame.
    scroll_req = 4'b0001;
    frame_req[63:0] = 64'h0011223344556677;
    req = 4'b0001;
    cyc();
    chk("t3_f0", frame_out, 64'h0011223344556677);
    repeat (4) cyc();
    chk("t3_f1", frame_out, 64'h1122334455667700);
    repeat (4) cyc();
    chk("t3_f2",   frame_out,  64'h2233445566770011);
    chk("t3_done", 64'(done),  64'(4'b0001));
    req = 4'b0000;
    scroll_req = 4'b0000;
    cyc(); cyc();

    // No preemption; withdrawal aborts without done.
    req = 4'b1000;
    cyc();
    chk("t4_grant", 64'(grant), 64'(4'b1000));
    cyc();
    req = 4'b1001;
    cyc(); cyc();
    chk("t4_nopre", 64'(grant), 64'(4'b1000));
    req = 4'b0001;
    cyc();
    chk("t4_abort_g", 64'(grant), 64'(4'b0));
    chk("t4_abort_d", 64'(done),  64'(4'b0));
    cyc();
    chk("t4_grant0", 64'(grant), 64'(4'b0001));
    req = 4'b0000;
    cyc(); cyc();

    // Inactivity timeout, and activity on the terminal tick.
    do_reset();
    repeat (11) cyc();
    chk("t5_pre", 64'(timeout), 64'(1'b0));
    cyc();
    chk("t5_pulse", 64'(timeout), 64'(1'b1));
    cyc();
    chk("t5_post", 64'(timeout), 64'(1'b0));
    do_reset();
    repeat (11) cyc();
    activity = 1'b1;
    cyc();
    activity = 1'b0;
    chk("t5_act", 64'(timeout), 64'(1'b0));
    repeat (12) cyc();
    chk("t5_restart", 64'(timeout), 64'(1'b1));

    // Request held through DONE is re-granted after one idle cycle.
    req = 4'b0010;
    cyc();
    repeat (7) cyc();
    cyc();
    chk("t6_done", 64'(done), 64'(4'b0010));
    cyc();
    chk("t6_idle_g", 64'(grant), 64'(4'b0));
    chk("t6_idle_d", 64'(done),  64'(4'b0));
    cyc();
    chk("t6_regrant", 64'(grant), 64'(4'b0010));
    chk("t6_nodone",  64'(done),  64'(4'b0));
    req = 4'b0000;
    cyc(); cyc();

    // Randomized traffic against the model.
    quiet = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 80 == 0) quiet = ($urandom_range(0, 2) == 0);
      if (quiet) begin
        req      = 4'b0000;
        activity = ($urandom_range(0, 24) == 0);
      end else begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 19) == 0) req[b] = ~req[b];
        activity = ($urandom_range(0, 7) == 0);
      end
      scroll_req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rand_frames();
      if ($urandom_range(0, 15) == 0) frame_base = {$urandom, $urandom};
      if ($urandom_range(0, 999) == 0) do_reset();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
